// File: rtl/flatten_pkg.sv
// Shared types and constants for the column flattener.
//   col_rec_t    : one buffered column record. Fields are sized for the widest
//                  supported configuration; narrower builds zero-extend on entry.
//   flat_state_t : pixel emitter states.
//   DEF_*_COLOR  : default ceiling and floor colours.
package flatten_pkg;

  localparam int unsigned REC_X_W     = 16;
  localparam int unsigned REC_LH_W    = 32;
  localparam int unsigned REC_COLOR_W = 32;

  localparam logic [7:0] DEF_CEIL_COLOR  = 8'h11;
  localparam logic [7:0] DEF_FLOOR_COLOR = 8'h22;

  typedef struct packed {
    logic [REC_X_W-1:0]     hcount;
    logic [REC_LH_W-1:0]    lineHeight;
    logic                   wallType;
    logic [REC_COLOR_W-1:0] mapData;
  } col_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } flat_state_t;

endpackage

// File: rtl/column_fifo.sv
// Synchronous FIFO of column records.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push       : write wr_data when not full
//   pop        : advance read pointer when not empty
//   rd_data    : head record (valid while !empty)
//   full/empty : occupancy flags
module column_fifo
  import flatten_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  col_rec_t wr_data,
  input  logic     pop,
  output col_rec_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  col_rec_t    mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/column_flattener.sv
// Column flattener: buffers raycaster column records and expands each one
// into SCREEN_HEIGHT pixels (ceiling / wall / floor) on a valid/ready stream.
//   pixel_clk_in, rst_in          : clock, synchronous active-low reset
//   col_valid_in / col_ready_out  : column record handshake
//   hcount_ray_in, lineHeight_in,
//   wallType_in, mapData_in       : column record fields
//   pix_valid_out / pix_ready_in  : pixel handshake
//   screenX_out, screenY_out,
//   screenData_out                : pixel position and colour
//   col_last_out, frame_last_out  : last row of column / of frame
// Build option: define FLAT_SHADE_EN to halve the wall colour on Y-side hits.
module column_flattener
  import flatten_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 240,
  parameter int unsigned COLOR_W       = 8,
  parameter int unsigned LH_W          = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [COLOR_W-1:0] CEIL_COLOR  = COLOR_W'(DEF_CEIL_COLOR),
  parameter logic [COLOR_W-1:0] FLOOR_COLOR = COLOR_W'(DEF_FLOOR_COLOR),
  localparam int unsigned X_W = $clog2(SCREEN_WIDTH),
  localparam int unsigned Y_W = $clog2(SCREEN_HEIGHT)
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               col_valid_in,
  output logic               col_ready_out,
  input  logic [X_W-1:0]     hcount_ray_in,
  input  logic [LH_W-1:0]    lineHeight_in,
  input  logic               wallType_in,
  input  logic [COLOR_W-1:0] mapData_in,
  output logic               pix_valid_out,
  input  logic               pix_ready_in,
  output logic [X_W-1:0]     screenX_out,
  output logic [Y_W-1:0]     screenY_out,
  output logic [COLOR_W-1:0] screenData_out,
  output logic               col_last_out,
  output logic               frame_last_out
);

  localparam logic signed [LH_W:0] MID = (LH_W+1)'(SCREEN_HEIGHT / 2);
  localparam logic signed [LH_W:0] BOT = (LH_W+1)'(SCREEN_HEIGHT - 1);
  localparam logic signed [LH_W:0] ONE = (LH_W+1)'(1);

  flat_state_t state, state_nx;

  col_rec_t rec_in, head, cur;
  logic     fifo_full, fifo_empty, push, pop;
  logic     unused_rec;

  logic [Y_W-1:0]     y_q, draw_start, draw_end;
  logic               last_row;
  logic [LH_W-1:0]    lh_cur;
  logic [COLOR_W-1:0] md_cur, wall_color;
  logic signed [LH_W:0] half_s, start_s, end_s;

  // Ready is forced low while reset is asserted.
  assign col_ready_out = rst_in && !fifo_full;
  assign push          = col_valid_in && col_ready_out;

  always_comb begin
    rec_in            = '0;
    rec_in.hcount     = REC_X_W'(hcount_ray_in);
    rec_in.lineHeight = REC_LH_W'(lineHeight_in);
    rec_in.wallType   = wallType_in;
    rec_in.mapData    = REC_COLOR_W'(mapData_in);
  end

  column_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (pixel_clk_in),
    .rst_n  (rst_in),
    .push   (push),
    .wr_data(rec_in),
    .pop    (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Upper record bits are zero-extension only.
  assign unused_rec = ^cur;

  assign lh_cur = cur.lineHeight[LH_W-1:0];
  assign md_cur = cur.mapData[COLOR_W-1:0];

`ifdef FLAT_SHADE_EN
  assign wall_color = cur.wallType ? (md_cur >> 1) : md_cur;
`else
  assign wall_color = md_cur;
`endif

  // half never exceeds 2^(LH_W-1)-1, so MID +/- half stays inside LH_W+1
  // signed bits; only the screen bounds need clamping.
  always_comb begin
    half_s  = {2'b00, lh_cur[LH_W-1:1]};
    start_s = MID - half_s;
    end_s   = MID + half_s - ONE;
  end

  assign last_row = (y_q == Y_W'(SCREEN_HEIGHT - 1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = EMIT;
      EMIT: begin
        if (pix_ready_in && last_row) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      cur        <= '0;
      y_q        <= '0;
      draw_start <= '0;
      draw_end   <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        cur <= head;
      end
      if (state == LOAD) begin
        draw_start <= start_s[LH_W] ? '0 : Y_W'(start_s);
        draw_end   <= (end_s > BOT) ? Y_W'(BOT) : Y_W'(end_s);
        y_q        <= '0;
      end else if (state == EMIT && pix_ready_in && !last_row) begin
        y_q <= y_q + 1'b1;
      end
    end
  end

  assign pix_valid_out  = (state == EMIT);
  assign screenX_out    = cur.hcount[X_W-1:0];
  assign screenY_out    = y_q;
  assign col_last_out   = pix_valid_out && last_row;
  assign frame_last_out = col_last_out && (screenX_out == X_W'(SCREEN_WIDTH - 1));

  always_comb begin
    screenData_out = '0;
    if (pix_valid_out) begin
      if (y_q < draw_start) begin
        screenData_out = CEIL_COLOR;
      end else if (y_q <= draw_end) begin
        screenData_out = wall_color;
      end else begin
        screenData_out = FLOOR_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_column_flattener.sv
// Self-checking bench for column_flattener: random and directed column
// records checked against a queue-based reference of the pixel stream.
module tb_column_flattener;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int XW = 9;
  localparam int YW = 8;

  logic          pixel_clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          col_valid_in = 1'b0;
  logic          col_ready_out;
  logic [XW-1:0] hcount_ray_in = '0;
  logic [15:0]   lineHeight_in = '0;
  logic          wallType_in = 1'b0;
  logic [7:0]    mapData_in = '0;
  logic          pix_valid_out;
  logic          pix_ready_in = 1'b0;
  logic [XW-1:0] screenX_out;
  logic [YW-1:0] screenY_out;
  logic [7:0]    screenData_out;
  logic          col_last_out;
  logic          frame_last_out;

  column_flattener #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H)
  ) dut (
    .pixel_clk_in  (pixel_clk_in),
    .rst_in        (rst_in),
    .col_valid_in  (col_valid_in),
    .col_ready_out (col_ready_out),
    .hcount_ray_in (hcount_ray_in),
    .lineHeight_in (lineHeight_in),
    .wallType_in   (wallType_in),
    .mapData_in    (mapData_in),
    .pix_valid_out (pix_valid_out),
    .pix_ready_in  (pix_ready_in),
    .screenX_out   (screenX_out),
    .screenY_out   (screenY_out),
    .screenData_out(screenData_out),
    .col_last_out  (col_last_out),
    .frame_last_out(frame_last_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  typedef struct {
    int x;
    int lh;
    bit wt;
    int md;
  } rec_t;

  rec_t q[$];
  int   exp_y = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_frame_last = 0;
  int   gap = 0;
  bit   gap_next = 1'b0;
  logic rst_edge = 1'b1;
  bit   after_rst = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference colour: ceiling above H/2-half, wall for half rows either side
  // of the midline, floor below.
  function automatic int exp_pixel(rec_t r, int y);
    int half;
    int wall;
    half = r.lh / 2;
    wall = r.md;
`ifdef FLAT_SHADE_EN
    if (r.wt) wall = r.md / 2;
`endif
    if (y < H / 2 - half) return 'h11;
    if (y < H / 2 + half) return wall;
    return 'h22;
  endfunction

  always @(posedge pixel_clk_in) rst_edge <= rst_in;

  always @(negedge pixel_clk_in) begin
    rec_t r;
    if (!rst_edge) begin
      check_eq("rst_pix_valid", 32'(pix_valid_out), 0);
      check_eq("rst_col_last", 32'(col_last_out), 0);
      check_eq("rst_frame_last", 32'(frame_last_out), 0);
      check_eq("rst_screen_x", 32'(screenX_out), 0);
      check_eq("rst_screen_y", 32'(screenY_out), 0);
      check_eq("rst_screen_data", 32'(screenData_out), 0);
      if (!rst_in) check_eq("rst_col_ready", 32'(col_ready_out), 0);
      after_rst = 1'b1;
    end else if (after_rst) begin
      check_eq("release_col_ready", 32'(col_ready_out), 1);
      after_rst = 1'b0;
    end

    if (!rst_in) begin
      q.delete();
      exp_y = 0;
      gap = 0;
    end else begin
      if (gap == 1) begin
        check_eq("bubble", 32'(pix_valid_out), 0);
        gap = gap_next ? 2 : 0;
      end else if (gap == 2) begin
        check_eq("reload", 32'(pix_valid_out), 1);
        gap = 0;
      end

      if (q.size() == 0) begin
        check_eq("idle_valid", 32'(pix_valid_out), 0);
      end else if (pix_valid_out) begin
        r = q[0];
        check_eq("pix_x", 32'(screenX_out), 32'(r.x));
        check_eq("pix_y", 32'(screenY_out), 32'(exp_y));
        check_eq("pix_data", 32'(screenData_out), 32'(exp_pixel(r, exp_y)));
        check_eq("col_last", 32'(col_last_out), 32'(exp_y == H - 1));
        check_eq("frame_last", 32'(frame_last_out), 32'(exp_y == H - 1 && r.x == W - 1));
        if (pix_ready_in) begin
          if (frame_last_out) n_frame_last++;
          if (exp_y == H - 1) begin
            void'(q.pop_front());
            exp_y = 0;
            gap = 1;
            gap_next = (q.size() != 0);
          end else begin
            exp_y++;
          end
        end
      end

      if (col_valid_in && col_ready_out)
        q.push_back('{int'(hcount_ray_in), int'(lineHeight_in), wallType_in, int'(mapData_in)});
    end
  end

  initial forever begin
    @(posedge pixel_clk_in);
    #1;
    if (rand_ready) pix_ready_in = ($urandom_range(0, 3) != 0);
  end

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_rec(input int x, input int lh, input bit wt, input int md);
    int n;
    n = 0;
    hcount_ray_in = XW'(x);
    lineHeight_in = 16'(lh);
    wallType_in   = wt;
    mapData_in    = 8'(md);
    col_valid_in  = 1'b1;
    do begin
      @(negedge pixel_clk_in);
      n++;
    end while (!col_ready_out && n < 5000);
    if (!col_ready_out) check_eq("push_timeout", 32'(col_ready_out), 1);
    @(posedge pixel_clk_in);
    #1 col_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge pixel_clk_in);
      n++;
    end
    check_eq("drain", 32'(q.size()), 0);
    @(posedge pixel_clk_in);
    #1;
  endtask

  initial begin
    int n;
    int stale;
    int lh_list[9];
    lh_list = '{0, 500, 240, 239, 1, 2, 3, 65535, 238};

    repeat (4) @(posedge pixel_clk_in);
    #1 rst_in = 1'b1;
    @(posedge pixel_clk_in);
    #1;

    // Single column, ready held high, with first-pixel latency.
    pix_ready_in = 1'b1;
    push_rec(5, 100, 1'b0, 'h80);
    @(negedge pixel_clk_in);
    check_eq("lat_idle", 32'(pix_valid_out), 0);
    @(negedge pixel_clk_in);
    check_eq("lat_load", 32'(pix_valid_out), 0);
    @(negedge pixel_clk_in);
    check_eq("lat_first", 32'(pix_valid_out), 1);
    @(posedge pixel_clk_in);
    #1;
    wait_drain(1000);

    // Height boundaries, back to back.
    foreach (lh_list[i]) push_rec(10 + i, lh_list[i], 1'b0, int'($urandom_range(1, 255)));
    wait_drain(5000);

    // Wall side shading.
    push_rec(20, 100, 1'b1, 'h80);
    push_rec(21, 500, 1'b1, 'h81);
    push_rec(22, 100, 1'b0, 'h80);
    wait_drain(2000);

    // Back-pressure: one column stalled, FIFO fills behind it.
    pix_ready_in = 1'b0;
    push_rec(30, 100, 1'b0, 'h33);
    n = 0;
    while (!pix_valid_out && n < 20) begin
      @(negedge pixel_clk_in);
      n++;
    end
    check_eq("bp_first_valid", 32'(pix_valid_out), 1);
    @(posedge pixel_clk_in);
    #1;
    for (int i = 1; i <= 4; i++) push_rec(30 + i, 40 * i, 1'b0, 'h30 + i);
    @(negedge pixel_clk_in);
    check_eq("bp_full_ready", 32'(col_ready_out), 0);
    check_eq("bp_queued", 32'(q.size()), 5);
    repeat (20) @(negedge pixel_clk_in);
    @(posedge pixel_clk_in);
    #1 pix_ready_in = 1'b1;
    wait_drain(3000);

    // Reset in the middle of a column with three records queued.
    for (int i = 0; i < 4; i++)
      push_rec(40 + i, int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    n = 0;
    while (!(exp_y == 100 && q.size() == 4) && n < 2000) begin
      @(negedge pixel_clk_in);
      n++;
    end
    check_eq("rst_reach_y100", 32'(exp_y), 100);
    @(posedge pixel_clk_in);
    #1 rst_in = 1'b0;
    repeat (2) @(posedge pixel_clk_in);
    #1 rst_in = 1'b1;
    stale = 0;
    repeat (300) begin
      @(negedge pixel_clk_in);
      if (pix_valid_out) stale++;
    end
    check_eq("no_stale", 32'(stale), 0);
    @(posedge pixel_clk_in);
    #1;
    push_rec(50, 120, 1'b0, 'h5a);
    wait_drain(1000);

    // Tail of a frame under random back-pressure and random record gaps.
    n_frame_last = 0;
    rand_ready = 1'b1;
    for (int c = 256; c < W; c++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge pixel_clk_in);
        #1;
      end
      push_rec(c,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(240, 65535)) : int'($urandom_range(0, 260)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end
    wait_drain(20000);
    rand_ready = 1'b0;
    check_eq("frame_last_count", 32'(n_frame_last), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
